store_bmp: RTL

STORE_BMP -- requirements
Module: store_bmp

---
 rtl/store_bmp_pkg.sv | 39 +++
 rtl/DEFINE.vh | 14 +
 rtl/bmp_byte_fifo.sv | 50 +++++
 rtl/store_bmp.sv | 128 ++++++++++++
 4 files changed

// File: rtl/store_bmp_pkg.sv
// Types, counter widths and the BMP header byte generator for store_bmp.
`include "DEFINE.vh"

package store_bmp_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PIXEL, S_DONE} state_t;

  localparam int CNT_W = $clog2(`BMP_TOTAL_SIZE + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HDR_N      = cnt_t'(`BMP_HEADER_SIZE);
  localparam cnt_t TOT_N      = cnt_t'(`BMP_TOTAL_SIZE);
  localparam cnt_t PREFETCH_N = cnt_t'(`BMP_HEADER_SIZE - 2);

  // After the "BM" magic every field starts at an offset of 2 mod 4, so the
  // header maps onto 32-bit little-endian words indexed by (idx-2)/4.
  function automatic logic [`BYTE_WIDTH-1:0] header_byte(input cnt_t idx,
                                                         input logic [31:0] xppm);
    logic [5:0]  j;
    logic [31:0] w;
    j = 6'(idx - cnt_t'(2));
    case (j[5:2])
      4'd0:    w = 32'(`BMP_TOTAL_SIZE);
      4'd2:    w = 32'(`BMP_HEADER_SIZE);
      4'd3:    w = 32'd40;
      4'd4:    w = 32'(`BMP_WIDTH);
      4'd5:    w = 32'(`BMP_HEIGHT);
      4'd6:    w = {16'd24, 16'd1};
      4'd8:    w = 32'(`BMP_PIXEL_SIZE);
      4'd9:    w = xppm;
      4'd10:   w = xppm;
      default: w = 32'd0;
    endcase
    if (idx == cnt_t'(0)) return 8'h42;
    if (idx == cnt_t'(1)) return 8'h4D;
    return w[8*j[1:0] +: 8];
  endfunction

endpackage

// File: rtl/DEFINE.vh
// Shared BMP geometry and bus widths, also used by the RAM loader.
`ifndef BMP_DEFINE_VH
`define BMP_DEFINE_VH

`define BMP_WIDTH        4
`define BMP_HEIGHT       2
`define BMP_HEADER_SIZE  54
// Rows are 3 bytes per pixel rounded up to a multiple of 4.
`define BMP_PIXEL_SIZE   (((((`BMP_WIDTH) * 3) + 3) / 4) * 4 * (`BMP_HEIGHT))
`define BMP_TOTAL_SIZE   ((`BMP_HEADER_SIZE) + (`BMP_PIXEL_SIZE))
`define BYTE_WIDTH       8
`define ADDR_WIDTH       16

`endif

// File: rtl/bmp_byte_fifo.sv
// Two-entry byte FIFO buffering RAM read data ahead of the output register.
`include "DEFINE.vh"

module bmp_byte_fifo (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [`BYTE_WIDTH-1:0] din,
  input  logic                   pop,
  output logic [`BYTE_WIDTH-1:0] dout,
  output logic [1:0]             count
);

  logic [`BYTE_WIDTH-1:0] mem_q [2];
  logic [`BYTE_WIDTH-1:0] mem_d [2];
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [1:0]             count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/store_bmp.sv
// Streams a 24-bpp BMP file: generated 54-byte header followed by pixel bytes
// read from RAM, through a single registered output stage with ready/valid.
`include "DEFINE.vh"

module store_bmp
  import store_bmp_pkg::*;
#(
  parameter logic [`ADDR_WIDTH-1:0] PIXEL_BASE = '0,
  parameter logic [31:0]            XPPM       = 32'd2835
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [`BYTE_WIDTH-1:0] RAM_Q,
  output logic                   RAM_valid,
  output logic [`ADDR_WIDTH-1:0] RAM_addr,
  output logic                   out_valid,
  output logic [`BYTE_WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic                   done
);

  localparam logic [`ADDR_WIDTH-1:0] PIXEL_END = PIXEL_BASE + `ADDR_WIDTH'(`BMP_PIXEL_SIZE);

  state_t                 state_q, state_d;
  cnt_t                   cnt_q, cnt_d;   // bytes accepted by the sink
  cnt_t                   nxt_q, nxt_d;   // bytes loaded into the output register
  logic [`ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   inflight_q, inflight_d;
  logic                   out_valid_q, out_valid_d;
  logic [`BYTE_WIDTH-1:0] out_data_q, out_data_d;
  logic                   done_q, done_d;

  logic                   fire, can_load, streaming, hdr_load, pix_load;
  logic                   fifo_pop, ram_rd;
  logic [1:0]             fifo_count, occupancy;
  logic [`BYTE_WIDTH-1:0] fifo_dout;

  bmp_byte_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (RAM_Q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    fire      = out_valid_q && out_ready;
    can_load  = !out_valid_q || out_ready;
    streaming = (state_q == S_HEADER) || (state_q == S_PIXEL);
    hdr_load  = streaming && (nxt_q < HDR_N);
    pix_load  = streaming && !hdr_load && (nxt_q < TOT_N) && (fifo_count != 2'd0);
    fifo_pop  = can_load && pix_load;
    // Counting this cycle's pop keeps one read issued per byte when streaming.
    occupancy = fifo_count - {1'b0, fifo_pop} + {1'b0, inflight_q};
    ram_rd    = ((state_q == S_PIXEL) || ((state_q == S_HEADER) && (nxt_q >= PREFETCH_N)))
                && (addr_q < PIXEL_END) && (occupancy < 2'd2);

    state_d     = state_q;
    cnt_d       = cnt_q;
    nxt_d       = nxt_q;
    addr_d      = addr_q + `ADDR_WIDTH'(ram_rd);
    inflight_d  = ram_rd;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          state_d     = S_HEADER;
          cnt_d       = '0;
          nxt_d       = '0;
          addr_d      = PIXEL_BASE;
          out_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      default: begin
        if (fire) cnt_d = cnt_q + cnt_t'(1);
        if (can_load && (hdr_load || pix_load)) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_load ? header_byte(nxt_q, XPPM) : fifo_dout;
          nxt_d       = nxt_q + cnt_t'(1);
        end else if (fire) begin
          out_valid_d = 1'b0;
        end
        if ((state_q == S_HEADER) && fire && (cnt_q == HDR_N - cnt_t'(1)))
          state_d = S_PIXEL;
        if ((state_q == S_PIXEL) && fire && (cnt_q == TOT_N - cnt_t'(1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nxt_q       <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nxt_q       <= nxt_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign RAM_valid = ram_rd;
  assign RAM_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule
